// File: rtl/ed25519_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ed25519_pkg
// Description : Shared definitions for the Ed25519 hash-to-scalar path:
//               loader FSM state encoding, digest word count, the group
//               order L and the 64-bit byte-swap helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ed25519_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    ST_COLLECT    = 3'd0,
    ST_WAIT_READY = 3'd1,
    ST_START      = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_OUTPUT     = 3'd4
  } state_t;

  // SHA-512 produces eight 64-bit words H0..H7
  localparam int unsigned c_WORDS = 8;

  // Ed25519 group order L = 2^252 + 27742317777372353535851937790883648493
  localparam logic [252:0] c_L =
    253'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;

  // Reverse byte order of a 64-bit word: w[63:56] lands in result[7:0].
  function automatic logic [63:0] bswap64(input logic [63:0] w);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      r[8*b +: 8] = w[8*(7-b) +: 8];
    end
    return r;
  endfunction

endpackage : ed25519_pkg
`default_nettype wire

// File: rtl/hash_scalar_loader.sv
`default_nettype none
// ============================================================================
// Module      : hash_scalar_loader
// Description : Collects the eight 64-bit words of a SHA-512 digest, packs
//               them as a 512-bit little-endian integer, hands the integer
//               to a Barrett reducer and returns the reduced 253-bit scalar
//               through a valid/ready output port.
// Revision    : 1.0 - initial release
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_word/in_valid/in_last digest word stream (H0 first, in_last on H7)
//   in_ready                 high only while collecting
//   red_in/red_ena           reducer operand and one-cycle start pulse
//   red_ready                reducer idle
//   red_comp_done/red_out    reducer result strobe and value
//   scalar_out/scalar_valid  reduced scalar, held until scalar_ready
//   err                      sticky framing / reducer-timeout flag
// ============================================================================
module hash_scalar_loader
  import ed25519_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [63:0]  in_word,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [511:0] red_in,
  output logic         red_ena,
  input  logic         red_ready,
  input  logic         red_comp_done,
  input  logic [252:0] red_out,
  output logic [252:0] scalar_out,
  output logic         scalar_valid,
  input  logic         scalar_ready,
  output logic         err
);

  localparam int unsigned c_TCW       = $clog2(TIMEOUT + 1);
  localparam logic [c_TCW-1:0] c_TLAST = c_TCW'(TIMEOUT - 1);
  localparam logic [2:0]       c_LAST_WORD = 3'(c_WORDS - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [2:0]         r_wcnt;
  logic [c_TCW-1:0]   r_tcnt;
  logic [511:0]       r_red_in;
  logic               r_red_ena;
  logic [252:0]       r_scalar_out;
  logic               r_scalar_valid;
  logic               r_err;

  logic               w_accept;
  logic               w_last_ok;
  logic               w_frame_err;
  logic               w_timeout;
  logic               w_capture;

  assign w_accept    = in_valid && (r_state == ST_COLLECT);
  // Framing is good only when in_last coincides exactly with the eighth word
  assign w_last_ok   = w_accept && in_last && (r_wcnt == c_LAST_WORD);
  assign w_frame_err = w_accept && (in_last != (r_wcnt == c_LAST_WORD));
  assign w_capture   = (r_state == ST_WAIT_DONE) && red_comp_done;
  // A result arriving in the final allowed cycle still wins over the timeout
  assign w_timeout   = (r_state == ST_WAIT_DONE) && !red_comp_done &&
                       (r_tcnt == c_TLAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_COLLECT:    if (w_last_ok) w_state_next = ST_WAIT_READY;
      ST_WAIT_READY: if (red_ready) w_state_next = ST_START;
      ST_START:      w_state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (w_capture)      w_state_next = ST_OUTPUT;
        else if (w_timeout) w_state_next = ST_COLLECT;
      end
      ST_OUTPUT:     if (scalar_ready) w_state_next = ST_COLLECT;
      default:       w_state_next = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Word counter and operand assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt   <= 3'd0;
      r_red_in <= '0;
    end else if (w_accept) begin
      if (w_frame_err) begin
        r_wcnt   <= 3'd0;
        r_red_in <= '0;
      end else begin
        r_wcnt <= r_wcnt + 3'd1;
        r_red_in[{r_wcnt, 6'd0} +: 64] <= bswap64(in_word);
      end
    end
  end

  // WAIT_DONE cycle counter; parked at zero in every other state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt <= '0;
    end else if (r_state == ST_WAIT_DONE) begin
      r_tcnt <= r_tcnt + 1'b1;
    end else begin
      r_tcnt <= '0;
    end
  end

  // Registered outputs, decoded from the next state so they align with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_red_ena      <= 1'b0;
      r_scalar_valid <= 1'b0;
      r_scalar_out   <= '0;
      r_err          <= 1'b0;
    end else begin
      r_red_ena      <= (w_state_next == ST_START);
      r_scalar_valid <= (w_state_next == ST_OUTPUT);
      if (w_capture) begin
        r_scalar_out <= red_out;
      end
      if (w_frame_err || w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign in_ready     = (r_state == ST_COLLECT);
  assign red_in       = r_red_in;
  assign red_ena      = r_red_ena;
  assign scalar_out   = r_scalar_out;
  assign scalar_valid = r_scalar_valid;
  assign err          = r_err;

endmodule : hash_scalar_loader
`default_nettype wire

// File: tb/tb_hash_scalar_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_hash_scalar_loader
// Description : Self-checking bench for hash_scalar_loader. The bench plays
//               the role of the digest source, the Barrett reducer and the
//               scalar consumer; expected operands and scalars come from a
//               byte-level model of the digest and a plain modulo by L.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hash_scalar_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  in_word;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [511:0] red_in;
  logic         red_ena;
  logic         red_ready;
  logic         red_comp_done;
  logic [252:0] red_out;
  logic [252:0] scalar_out;
  logic         scalar_valid;
  logic         scalar_ready;
  logic         err;

  int checks = 0;
  int errors = 0;

  // Digest as 64 bytes in SHA-512 output order; byte 0 is H0[63:56]
  logic [7:0]   dig [64];
  logic [511:0] grp_l;
  logic         exp_err;

  hash_scalar_loader #(.TIMEOUT(255)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_word       (in_word),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .red_in        (red_in),
    .red_ena       (red_ena),
    .red_ready     (red_ready),
    .red_comp_done (red_comp_done),
    .red_out       (red_out),
    .scalar_out    (scalar_out),
    .scalar_valid  (scalar_valid),
    .scalar_ready  (scalar_ready),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word i of the digest in big-endian word form (first byte in the MSBs)
  function automatic logic [63:0] hword(input int i);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[8*(7-j) +: 8] = dig[8*i + j];
    return w;
  endfunction

  // The digest read as a little-endian 512-bit integer
  function automatic logic [511:0] digest_int();
    logic [511:0] v;
    v = '0;
    for (int k = 0; k < 64; k++) v = v + ({504'd0, dig[k]} << (8*k));
    return v;
  endfunction

  task automatic set_zero();
    for (int k = 0; k < 64; k++) dig[k] = 8'h00;
  endtask

  task automatic set_random();
    for (int k = 0; k < 64; k++) dig[k] = 8'($urandom);
  endtask

  task automatic send_words(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        in_valid = 1'b0;
        in_word  = {$urandom, $urandom};
        in_last  = 1'($urandom);
        @(negedge clk);
      end
      chk("in_ready_collect", 512'(in_ready), 512'd1);
      in_valid = 1'b1;
      in_word  = hword(i);
      in_last  = (i == n - 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Full transaction: source -> reducer handshake -> scalar consumer.
  // With do_done=0 it stops right after the red_ena pulse is observed.
  task automatic run_digest(input int max_gap, input int rr_delay, input int done_delay,
                            input int hold, input bit do_done);
    logic [511:0] red_exp;
    logic [252:0] sc_exp;
    red_exp   = digest_int();
    sc_exp    = 253'(red_exp % grp_l);
    red_ready = (rr_delay == 0);
    send_words(8, max_gap);
    chk("ena_low_wait_ready", 512'(red_ena), 512'd0);
    chk("in_ready_low_busy", 512'(in_ready), 512'd0);
    for (int k = 0; k < rr_delay; k++) begin
      @(negedge clk);
      chk("ena_low_reducer_busy", 512'(red_ena), 512'd0);
    end
    red_ready = 1'b1;
    @(negedge clk);
    chk("ena_pulse", 512'(red_ena), 512'd1);
    chk("red_in_value", red_in, red_exp);
    if (!do_done) return;
    @(negedge clk);
    chk("ena_single_cycle", 512'(red_ena), 512'd0);
    repeat (done_delay) begin
      @(negedge clk);
      chk("red_in_stable", red_in, red_exp);
      chk("no_valid_before_done", 512'(scalar_valid), 512'd0);
    end
    red_comp_done = 1'b1;
    red_out       = sc_exp;
    @(negedge clk);
    red_comp_done = 1'b0;
    red_out       = 253'($urandom);
    chk("scalar_valid", 512'(scalar_valid), 512'd1);
    chk("scalar_value", 512'(scalar_out), 512'(sc_exp));
    chk("in_ready_output", 512'(in_ready), 512'd0);
    scalar_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_word  = {$urandom, $urandom};
      in_last  = 1'($urandom);
      @(negedge clk);
      chk("hold_valid", 512'(scalar_valid), 512'd1);
      chk("hold_value", 512'(scalar_out), 512'(sc_exp));
      chk("hold_in_ready", 512'(in_ready), 512'd0);
    end
    in_valid     = 1'b0;
    in_last      = 1'b0;
    scalar_ready = 1'b1;
    @(negedge clk);
    scalar_ready = 1'b0;
    chk("valid_drop", 512'(scalar_valid), 512'd0);
    chk("back_collect", 512'(in_ready), 512'd1);
    chk("err_flag", 512'(err), 512'(exp_err));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, 512'(in_ready), 512'd1);
    chk({tag, "_red_ena"}, 512'(red_ena), 512'd0);
    chk({tag, "_scalar_valid"}, 512'(scalar_valid), 512'd0);
    chk({tag, "_err"}, 512'(err), 512'd0);
    chk({tag, "_red_in"}, red_in, 512'd0);
    chk({tag, "_scalar_out"}, 512'(scalar_out), 512'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    grp_l         = (512'd1 << 252) + 512'h14def9dea2f79cd65812631a5cf5d3ed;
    exp_err       = 1'b0;
    rst           = 1'b1;
    in_word       = '0;
    in_valid      = 1'b0;
    in_last       = 1'b0;
    red_ready     = 1'b1;
    red_comp_done = 1'b0;
    red_out       = '0;
    scalar_ready  = 1'b0;
    #2;
    check_reset_values("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // All-zero digest
    set_zero();
    run_digest(0, 0, 0, 0, 1'b1);

    // Single 1 byte at digest byte 0 -> integer 1
    set_zero();
    dig[0] = 8'h01;
    run_digest(0, 0, 2, 0, 1'b1);

    // Digest encoding L little-endian, first back-to-back, then with gaps
    set_zero();
    for (int k = 0; k < 32; k++) dig[k] = grp_l[8*k +: 8];
    run_digest(0, 0, 1, 0, 1'b1);
    run_digest(3, 2, 3, 0, 1'b1);

    // Consumer stalls 20 cycles while the source keeps pushing
    set_random();
    run_digest(1, 0, 0, 20, 1'b1);

    // Random digests with random gaps and reducer delays
    for (int t = 0; t < 3; t++) begin
      set_random();
      run_digest(2, $urandom_range(3, 0), $urandom_range(6, 0), $urandom_range(3, 0), 1'b1);
    end

    // Framing error: in_last on the fifth word
    set_random();
    send_words(5, 1);
    exp_err = 1'b1;
    chk("frame_err", 512'(err), 512'd1);
    chk("frame_in_ready", 512'(in_ready), 512'd1);
    repeat (4) begin
      @(negedge clk);
      chk("frame_no_ena", 512'(red_ena), 512'd0);
    end
    set_random();
    run_digest(1, 0, 1, 0, 1'b1);

    // Reducer timeout
    pulse_reset();
    set_random();
    run_digest(0, 0, 0, 0, 1'b0);
    repeat (255) @(negedge clk);
    chk("timeout_not_yet", 512'(err), 512'd0);
    chk("timeout_still_busy", 512'(in_ready), 512'd0);
    @(negedge clk);
    chk("timeout_err", 512'(err), 512'd1);
    chk("timeout_collect", 512'(in_ready), 512'd1);
    chk("timeout_no_valid", 512'(scalar_valid), 512'd0);

    // Reset in the middle of WAIT_DONE, then a stale result strobe
    pulse_reset();
    set_random();
    run_digest(0, 0, 0, 0, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    red_comp_done = 1'b1;
    red_out       = 253'h1abcdef;
    @(negedge clk);
    red_comp_done = 1'b0;
    check_reset_values("stale_done");

    // Normal operation resumes after reset
    set_random();
    run_digest(1, 1, 2, 2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_hash_scalar_loader
`default_nettype wire

// File: doc/hash_scalar_loader.md
HASH_SCALAR_LOADER -- requirements
Module: hash_scalar_loader

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-002 SHALL have in_word  in  64  SHA-512 digest word H0..H7, H0 first.
REQ-003 SHALL have in_valid  in  1  in_word valid; in_last  in  1  marks H7; in_ready  out  1  word accepted when in_valid&&in_ready.
REQ-004 SHALL have red_in  out  512  operand to barrett_reduce; red_ena  out  1  start pulse; red_ready  in  1  reducer idle.
REQ-005 SHALL have red_comp_done  in  1  reducer result strobe; red_out  in  253  reducer result, valid only while red_comp_done=1.
REQ-006 SHALL have scalar_out  out  253  reduced scalar; scalar_valid  out  1; scalar_ready  in  1.
REQ-007 SHALL have err  out  1  sticky framing/timeout error, cleared only by rst.
REQ-008 SHALL have parameter TIMEOUT, default 255, meaning max cycles in WAIT_DONE.

Function
REQ-009 SHALL place each accepted word i (0..7) byte-swapped at red_in[64i+63:64i], so digest byte 0 (H0[63:56]) becomes red_in[7:0] (little-endian integer).
REQ-010 SHALL implement states COLLECT, WAIT_READY, START, WAIT_DONE, OUTPUT; the reset state is COLLECT.
REQ-011 COLLECT: in_ready=1, 3-bit word counter increments per accepted word.
REQ-012 An accept with counter=7 and in_last=1 SHALL move to WAIT_READY next cycle; the counter resets to 0.
REQ-013 An accept with in_last=1 and counter<7, or with counter=7 and in_last=0, SHALL set err, discard the partial digest, reset the counter, and stay in COLLECT.
REQ-014 WAIT_READY: in_ready=0; red_ready sampled 1 SHALL move to START.
REQ-015 START: red_ena=1 for exactly one cycle (registered output), then WAIT_DONE.
REQ-016 red_in SHALL be held stable from WAIT_READY entry until leaving WAIT_DONE.
REQ-017 WAIT_DONE: red_comp_done=1 SHALL capture red_out into scalar_out and move to OUTPUT.
REQ-018 WAIT_DONE: a cycle counter reaching TIMEOUT without red_comp_done SHALL set err and return to COLLECT; scalar_valid is not asserted.
REQ-019 OUTPUT: scalar_valid=1 and scalar_out stable until scalar_ready=1, then COLLECT; in_ready=0 throughout.
REQ-020 Latency SHALL be 2 cycles from the last-word accept to red_ena (red_ready=1), and 1 cycle from red_comp_done to scalar_valid.
REQ-021 red_comp_done outside WAIT_DONE SHALL be ignored; in_valid outside COLLECT SHALL be ignored (not accepted).

Reset
REQ-022 rst SHALL asynchronously force state COLLECT, counters 0, in_ready=1 (after reset), red_ena=0, scalar_valid=0, err=0, red_in=0, scalar_out=0.
REQ-023 rst in any state, including mid-WAIT_DONE, SHALL abandon the operation; a later red_comp_done SHALL be ignored.

Structure
REQ-024 Package ed25519_pkg SHALL hold the state enum, the word count 8, the group order L (253 bits), and the bswap64 function.
REQ-025 No sub-module SHALL be required; the byte swap SHALL be the package function.

Verification
REQ-026 All-zero digest (8 words, last on H7), with barrett_reduce attached -> red_in=0, scalar_out=0, scalar_valid one cycle after red_comp_done.
REQ-027 H0=64'h0100000000000000, H1..H7=0 -> red_in=512'h1, scalar_out=253'h1; red_ena exactly 1 cycle, 2 cycles after the last accept.
REQ-028 Digest encoding L little-endian (H4..H7=0) -> red_in=L, scalar_out=0; random in_valid gaps give an identical result.
REQ-029 in_last on the 5th word -> err=1, in_ready stays 1, red_ena never asserted; the next valid 8-word digest completes normally.
REQ-030 Hold scalar_ready=0 for 20 cycles -> scalar_valid and scalar_out stable and in_ready=0 throughout; on release -> COLLECT.
REQ-031 Stub reducer never asserts red_comp_done -> err=1 after 255 WAIT_DONE cycles, back in COLLECT; separately, rst mid-WAIT_DONE -> all outputs at reset values, and a later red_comp_done is ignored.
